// File: rtl/dest_sel_pkg.sv
// Shared constants, types and the slot-select helper for the destination-register selector.
// Candidate inputs are zero-extended into fixed-pitch slots so one helper serves any WIDTH/NUM_IN.
package dest_sel_pkg;

    localparam int DEF_WIDTH = 5;
    localparam int DEF_CNT_W = 8;
    localparam int REG_ZERO  = 0;

    localparam int MAX_IN   = 16;
    localparam int MAX_W    = 32;
    localparam int MAX_BITS = MAX_IN * MAX_W;

    typedef logic [MAX_W-1:0]    slot_t;
    typedef logic [MAX_BITS-1:0] slot_vec_t;

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_DRAIN,
        ACT_FILL_OUT,
        ACT_FILL_SKID,
        ACT_EMPTY
    } skid_act_e;

    // Returns slot `sel`, or zero when the index names no real input.
    function automatic slot_t dest_select(input slot_vec_t slots,
                                          input int unsigned sel,
                                          input int unsigned num_in);
        slot_vec_t shifted;
        if (sel >= num_in) begin
            return '0;
        end
        shifted = slots >> (sel * MAX_W);
        return shifted[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/dest_skid_buf.sv
// Generic 2-entry valid/ready skid buffer: an output register plus one overflow register.
// Upstream readiness depends only on the skid register, never on downstream ready.
module dest_skid_buf
    import dest_sel_pkg::*;
#(
    parameter int P_W = 8
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           push,
    input  logic [P_W-1:0] push_data,
    output logic           ready,
    input  logic           out_ready,
    output logic           out_valid,
    output logic [P_W-1:0] out_data
);

    logic           out_valid_reg;
    logic [P_W-1:0] out_data_reg;
    logic           skid_valid_reg;
    logic [P_W-1:0] skid_data_reg;
    logic           pop;
    skid_act_e      act;

    assign pop = out_valid_reg & out_ready;

    always_comb begin
        act = ACT_HOLD;
        if (skid_valid_reg && pop) begin
            act = ACT_DRAIN;
        end else if (!skid_valid_reg && push && (!out_valid_reg || pop)) begin
            act = ACT_FILL_OUT;
        end else if (!skid_valid_reg && push) begin
            act = ACT_FILL_SKID;
        end else if (pop) begin
            act = ACT_EMPTY;
        end
    end

    // Data registers keep their contents when emptied; only the valid bits clear.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
        end else begin
            case (act)
                ACT_DRAIN: begin
                    out_data_reg   <= skid_data_reg;
                    skid_valid_reg <= 1'b0;
                end
                ACT_FILL_OUT: begin
                    out_data_reg  <= push_data;
                    out_valid_reg <= 1'b1;
                end
                ACT_FILL_SKID: begin
                    skid_data_reg  <= push_data;
                    skid_valid_reg <= 1'b1;
                end
                ACT_EMPTY: begin
                    out_valid_reg <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign ready     = ~skid_valid_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

endmodule

// File: rtl/dest_sel_pipe.sv
// N-way register-destination selector: mux by sel, drop writes to register 0,
// count the drops, flag illegal selects, and hand results to a 2-entry skid stage.
module dest_sel_pipe
    import dest_sel_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int NUM_IN        = 4,
    parameter int SEL_W         = $clog2(NUM_IN),
    parameter int SUPPRESS_ZERO = 1,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] data_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic                    sel_err
);

    localparam int PAY_W = WIDTH + SEL_W;

    slot_vec_t        slots;
    slot_t            sel_wide;
    logic [WIDTH-1:0] sel_value;
    logic             sel_ok;
    logic             suppress;
    logic             accept;
    logic             push;
    logic             buf_ready;
    logic [PAY_W-1:0] buf_data;

    logic [CNT_W-1:0] drop_cnt_reg;
    logic [CNT_W-1:0] drop_cnt_next;
    logic             sel_err_reg;
    logic             sel_err_next;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_IN; gi++) begin : g_slot
            if (gi < NUM_IN) begin : g_used
                assign slots[gi*MAX_W +: MAX_W] = slot_t'(data_in[gi*WIDTH +: WIDTH]);
            end else begin : g_pad
                assign slots[gi*MAX_W +: MAX_W] = '0;
            end
        end
    endgenerate

    assign sel_wide  = dest_select(slots, 32'(sel), NUM_IN);
    assign sel_value = sel_wide[WIDTH-1:0];

    generate
        if (WIDTH < MAX_W) begin : g_hi
            logic unused_sel_hi;
            assign unused_sel_hi = ^sel_wide[MAX_W-1:WIDTH];
        end
    endgenerate

    assign sel_ok   = (32'(sel) < 32'(NUM_IN));
    assign suppress = (SUPPRESS_ZERO != 0) && (sel_value == WIDTH'(REG_ZERO));
    assign in_ready = reset_n & buf_ready;
    assign accept   = in_valid & in_ready;
    assign push     = accept & ~suppress;

    always_comb begin
        drop_cnt_next = drop_cnt_reg;
        sel_err_next  = sel_err_reg;
        if (accept && suppress && (drop_cnt_reg != {CNT_W{1'b1}})) begin
            drop_cnt_next = drop_cnt_reg + CNT_W'(1);
        end
        if (accept && !sel_ok) begin
            sel_err_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt_reg <= '0;
            sel_err_reg  <= 1'b0;
        end else begin
            drop_cnt_reg <= drop_cnt_next;
            sel_err_reg  <= sel_err_next;
        end
    end

    dest_skid_buf #(
        .P_W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({sel, sel_value}),
        .ready     (buf_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (buf_data)
    );

    assign out_data = buf_data[WIDTH-1:0];
    assign out_sel  = buf_data[PAY_W-1:WIDTH];
    assign drop_cnt = drop_cnt_reg;
    assign sel_err  = sel_err_reg;

endmodule

// File: doc/dest_sel_pipe.md
Name: dest_sel_pipe

Overview:
- Parametrised N-way register-destination selector for the MIPS datapath.
- Picks one of NUM_IN register numbers using sel and registers the result.
- Passes the result through a 2-entry valid/ready skid stage toward the write-back/hazard logic.
- Suppresses writes to register 0 and flags illegal select codes.

Parameters:
- WIDTH, 5, bit width of each register number.
- NUM_IN, 4, number of candidate inputs (2..16).
- SEL_W, $clog2(NUM_IN), select width; derived, not overridden.
- SUPPRESS_ZERO, 1, when 1 a selected value of 0 is consumed but not forwarded.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  synchronous reset, active-low.
- in_valid  in  1  upstream offers sel/data_in.
- in_ready  out  1  block can accept this cycle.
- sel  in  SEL_W  input index.
- data_in  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  1  out_data/out_sel hold a valid entry.
- out_ready  in  1  downstream consumes when out_valid & out_ready.
- out_data  out  WIDTH  selected register number.
- out_sel  out  SEL_W  sel value that produced out_data.
- drop_cnt  out  CNT_W  count of suppressed zero destinations, saturating.
- sel_err  out  1  sticky flag: sel >= NUM_IN was accepted.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-low on reset_n; all state updates on the rising edge of clk.
  - While reset_n=0: out_valid=0, out_data=0, out_sel=0, skid entry invalid, drop_cnt=0, sel_err=0, in_ready=0.
  - The first cycle after reset_n rises: in_ready=1.
- Accept and select:
  - accept = in_valid & in_ready.
  - Selected value v = data_in[sel*WIDTH +: WIDTH] when sel < NUM_IN.
  - When sel >= NUM_IN, v = 0 and sel_err sets on accept; it clears only on reset.
- Zero suppression (SUPPRESS_ZERO=1 and v==0 on accept):
  - Nothing is enqueued.
  - drop_cnt increments by 1 and saturates at 2^CNT_W-1.
  - When SUPPRESS_ZERO=0, v=0 is forwarded like any other value and drop_cnt stays 0.
- Storage:
  - Output register (out_*) plus one skid register (skid_data, skid_sel, skid_valid).
  - in_ready = reset_n & ~skid_valid, taken from a register and never a combinational path from out_ready.
- Per-cycle rules; let pop = out_valid & out_ready and push = accept & not suppressed:
  - skid_valid=1 and pop: output register loads the skid entry; skid_valid clears. No accept is possible this cycle.
  - skid_valid=0, push, and (out_valid=0 or pop): output register loads v/sel; out_valid=1.
  - skid_valid=0, push, out_valid=1 and no pop: skid loads v/sel; skid_valid=1; the output holds.
  - pop with no push and skid empty: out_valid clears. out_data/out_sel keep their last value.
- Timing:
  - Latency from accept to out_valid is 1 cycle.
  - Sustained throughput is 1 entry/cycle while out_ready=1.
- Ordering: entries leave in acceptance order, with no loss and no duplication.
- Stability: while out_valid=1 and out_ready=0, out_data/out_sel must not change.
- Counter and flag timing: drop_cnt and sel_err update in the same edge as the accept.
- Reset mid-operation: reset_n=0 for one cycle discards both entries and clears counters. in_ready is 0 during that cycle.

Decomposition:
- Package dest_sel_pkg holds:
  - REG_ZERO constant (0).
  - Default WIDTH/CNT_W localparams.
  - A select function returning the slice, or 0 when out of range.
- One sub-module: dest_skid_buf, a generic 2-entry valid/ready skid buffer parametrised by payload width (WIDTH+SEL_W).
- The top level holds the mux, zero suppression, drop_cnt and sel_err.

Test Plan:
- Reset and basic path: reset_n=0 for 2 cycles, then sel=2, data_in={E3=31,E2=17,E1=9,E0=5}, in_valid=1, out_ready=1 → next cycle out_valid=1, out_data=17, out_sel=2; drop_cnt=0, sel_err=0.
- Backpressure: out_ready=0; push 9 (sel=1) then 31 (sel=3) → out_data holds 9, in_ready=0 after the second push. Raise out_ready → 9 then 31 leave on consecutive cycles, and in_ready returns to 1.
- Zero suppression: E0=0, sel=0 accepted 3 times → out_valid stays 0 and drop_cnt=3. Then with CNT_W=2, 5 drops → drop_cnt=3 (saturated).
- Illegal select: NUM_IN=3, sel=3 accepted → sel_err=1, nothing output (SUPPRESS_ZERO=1), drop_cnt+1. sel_err stays 1 until reset.
- Streaming: 16 back-to-back accepts of values 1..16 with random out_ready → output sequence exactly 1..16 and out_data stable whenever stalled.
- Mid-operation reset: both entries full, reset_n=0 for 1 cycle → out_valid=0, in_ready=0 that cycle, in_ready=1 the next, and no stale entry appears.
